// File: rtl/toggle_event_rx.sv
// toggle_event_rx: receive end of a toggle-encoded event link.
//
// The sender flips t_in once per event. t_in is synchronised into the clk
// domain. Each level change becomes a one-cycle evt_pulse. Events are held as
// a saturating pending count behind a valid/ready handshake. A wrapping total
// is kept in evt_count.
//
// Optional feature macro: TOG_RX_ACK_EN
//   defined   - ack_out is a register that flips once per consumed event.
//   undefined - ack_out is tied to 0 and no ack register is built.
//
// Ports:
//   clk        in             rising-edge clock
//   rst        in             asynchronous active-high reset
//   t_in       in             toggle line from the sender (asynchronous)
//   evt_pulse  out            one-cycle pulse per detected toggle
//   evt_valid  out            at least one event pending
//   evt_ready  in             consumer accepts one event on evt_valid && evt_ready
//   pending    out [PEND_W]   outstanding events, saturates at 2^PEND_W-1
//   evt_count  out [CNT_W]    total detected events, wrapping
//   overflow   out            sticky: event arrived while pending was full
//   clr_ovf    in             synchronous clear of overflow (set wins)
//   ack_out    out            toggles once per consumed event
module toggle_event_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    output logic              evt_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              ack_out
);

    localparam int unsigned WU_W = $clog2(SYNC_STAGES + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic {StWarmup, StRun} state_e;

    state_e              state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                sync_last;
    logic                prev_q;
    logic                pulse_q;
    logic [WU_W-1:0]     wu_q;
    logic [PEND_W-1:0]   pend_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic                inc;
    logic                dec;
    logic                full;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, sync_q[0] is the capture flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
        end
    end

    // Warm-up holds pulses off until the chain has flushed the reset zeros and
    // prev has caught the settled level. The chain's last stage only settles on
    // edge SYNC_STAGES, so prev samples it one edge later before RUN begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWarmup;
            wu_q    <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q <= sync_last;
            unique case (state_q)
                StWarmup: begin
                    pulse_q <= 1'b0;
                    if (wu_q == WU_W'(SYNC_STAGES)) begin
                        state_q <= StRun;
                    end else begin
                        wu_q <= wu_q + 1'b1;
                    end
                end
                StRun: begin
                    pulse_q <= sync_last ^ prev_q;
                end
            endcase
        end
    end

    assign inc  = pulse_q;
    assign dec  = evt_valid && evt_ready;
    assign full = (pend_q == PEND_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Simultaneous inc and dec cancel, even when full.
            if (inc && !dec) begin
                if (!full) begin
                    pend_q <= pend_q + 1'b1;
                end
            end else if (dec && !inc) begin
                pend_q <= pend_q - 1'b1;
            end
            if (inc && !dec && full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef TOG_RX_ACK_EN
    logic ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else if (dec) begin
            ack_q <= ~ack_q;
        end
    end

    assign ack_out = ack_q;
`else
    assign ack_out = 1'b0;
`endif

    assign evt_pulse = pulse_q;
    assign evt_valid = (pend_q != '0);
    assign pending   = pend_q;
    assign evt_count = cnt_q;
    assign overflow  = ovf_q;

endmodule
